// File: rtl/usb_tx_packet_builder.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_packet_builder
// Description : Assembles a USB handshake or data packet (SYNC, PID, payload,
//               CRC16) into a flat byte-addressed register for the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_packet_builder #(
    parameter int         MAX_DATA_BYTES = 64,
    parameter logic [7:0] SYNC_BYTE      = 8'h01,
    parameter int         CNT_W          = $clog2(MAX_DATA_BYTES + 1),
    parameter int         LEN_W          = $clog2(MAX_DATA_BYTES + 5)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [3:0]                      pid,
    input  logic [CNT_W-1:0]                data_count,
    input  logic                            abort,
    input  logic [7:0]                      tx_data,
    input  logic                            tx_data_valid,
    output logic                            get_tx_data,
    output logic                            busy,
    output logic                            packet_done,
    output logic                            packet_error,
    output logic [LEN_W-1:0]                packet_len,
    output logic [LEN_W+2:0]                packet_bits,
    output logic [8*(MAX_DATA_BYTES+4)-1:0] packet_tx
);

    localparam int              c_nbytes  = MAX_DATA_BYTES + 4;
    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_DATA_BYTES);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_sync   = 3'd1;
    localparam logic [2:0] c_st_pid    = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_crc_lo = 3'd4;
    localparam logic [2:0] c_st_crc_hi = 3'd5;
    localparam logic [2:0] c_st_done   = 3'd6;

    logic [2:0]          r_state;
    logic [3:0]          r_pid;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_cnt;
    logic [15:0]         r_crc;
    logic [LEN_W-1:0]    r_len;
    logic [8*c_nbytes-1:0] r_packet_tx;
    logic                r_get_tx_data;
    logic                r_packet_done;
    logic                r_packet_error;

    logic                w_start_ok;
    logic                w_consume;
    logic                w_last;
    logic                w_wr_en;
    logic [7:0]          w_wr_byte;

    // Reflected CRC-16 (poly 0xA001), one byte processed LSB-first.
    function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] v;
        v = crc ^ {8'h00, data};
        for (int b = 0; b < 8; b++) begin
            v = v[0] ? ((v >> 1) ^ 16'hA001) : (v >> 1);
        end
        return v;
    endfunction

    assign w_start_ok = ((pid[1:0] == 2'b11) || (pid[1:0] == 2'b10)) && (data_count <= c_max_cnt);
    assign w_consume  = (r_state == c_st_data) && tx_data_valid && !abort;
    assign w_last     = ((r_cnt + CNT_W'(1)) == r_count);

    always_comb begin
        w_wr_byte = 8'h00;
        w_wr_en   = 1'b0;
        case (r_state)
            c_st_sync: begin
                w_wr_byte = SYNC_BYTE;
                w_wr_en   = !abort;
            end
            c_st_pid: begin
                w_wr_byte = {~r_pid, r_pid};
                w_wr_en   = !abort;
            end
            c_st_data: begin
                w_wr_byte = tx_data;
                w_wr_en   = w_consume;
            end
            c_st_crc_lo: begin
                w_wr_byte = ~r_crc[7:0];
                w_wr_en   = !abort;
            end
            c_st_crc_hi: begin
                w_wr_byte = ~r_crc[15:8];
                w_wr_en   = !abort;
            end
            default: begin
                w_wr_byte = 8'h00;
                w_wr_en   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_pid          <= 4'h0;
            r_count        <= '0;
            r_cnt          <= '0;
            r_crc          <= 16'hFFFF;
            r_len          <= '0;
            r_packet_tx    <= '0;
            r_get_tx_data  <= 1'b0;
            r_packet_done  <= 1'b0;
            r_packet_error <= 1'b0;
        end else begin
            r_packet_done  <= 1'b0;
            r_packet_error <= 1'b0;

            // Every byte lands at the current length, then the length advances.
            if (w_wr_en) begin
                for (int k = 0; k < c_nbytes; k++) begin
                    if (r_len == LEN_W'(k)) begin
                        r_packet_tx[8*k +: 8] <= w_wr_byte;
                    end
                end
                r_len <= r_len + LEN_W'(1);
            end

            if ((r_state != c_st_idle) && abort) begin
                r_state       <= c_st_idle;
                r_get_tx_data <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start) begin
                            if (w_start_ok) begin
                                r_pid       <= pid;
                                r_count     <= data_count;
                                r_packet_tx <= '0;
                                r_len       <= '0;
                                r_state     <= c_st_sync;
                            end else begin
                                r_packet_error <= 1'b1;
                            end
                        end
                    end
                    c_st_sync: begin
                        r_state <= c_st_pid;
                    end
                    c_st_pid: begin
                        r_crc <= 16'hFFFF;
                        r_cnt <= '0;
                        if (r_pid[1:0] == 2'b10) begin
                            r_state       <= c_st_done;
                            r_packet_done <= 1'b1;
                        end else if (r_count == '0) begin
                            r_state <= c_st_crc_lo;
                        end else begin
                            r_state       <= c_st_data;
                            r_get_tx_data <= 1'b1;
                        end
                    end
                    c_st_data: begin
                        if (w_consume) begin
                            r_crc <= f_crc16_byte(r_crc, tx_data);
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (w_last) begin
                                r_state       <= c_st_crc_lo;
                                r_get_tx_data <= 1'b0;
                            end
                        end
                    end
                    c_st_crc_lo: begin
                        r_state <= c_st_crc_hi;
                    end
                    c_st_crc_hi: begin
                        r_state       <= c_st_done;
                        r_packet_done <= 1'b1;
                    end
                    c_st_done: begin
                        r_state <= c_st_idle;
                    end
                    default: begin
                        r_state       <= c_st_idle;
                        r_get_tx_data <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign get_tx_data  = r_get_tx_data;
    assign busy         = (r_state != c_st_idle);
    assign packet_done  = r_packet_done;
    assign packet_error = r_packet_error;
    assign packet_len   = r_len;
    assign packet_bits  = {r_len, 3'b000};
    assign packet_tx    = r_packet_tx;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_packet_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_packet_builder
// Description : Directed bench; a byte-stream model predicts every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_packet_builder;

    localparam int MAXB  = 64;
    localparam int NB    = MAXB + 4;
    localparam int CNT_W = $clog2(MAXB + 1);
    localparam int LEN_W = $clog2(MAXB + 5);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       pid = 4'h0;
    logic [CNT_W-1:0] data_count = '0;
    logic             abort = 1'b0;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_data_valid = 1'b0;
    logic             get_tx_data;
    logic             busy;
    logic             packet_done;
    logic             packet_error;
    logic [LEN_W-1:0] packet_len;
    logic [LEN_W+2:0] packet_bits;
    logic [8*NB-1:0]  packet_tx;

    usb_tx_packet_builder #(.MAX_DATA_BYTES(MAXB), .SYNC_BYTE(8'h01)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pid(pid), .data_count(data_count),
        .abort(abort), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .get_tx_data(get_tx_data), .busy(busy), .packet_done(packet_done),
        .packet_error(packet_error), .packet_len(packet_len),
        .packet_bits(packet_bits), .packet_tx(packet_tx)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    bit         cmp_en = 1'b0;
    logic       exp_busy = 1'b0, exp_get = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    int         exp_len = 0;
    logic [7:0] exp_bytes [0:NB-1];
    logic [7:0] pay [0:MAXB-1];

    task automatic check(input string name, input logic [8*NB-1:0] act, input logic [8*NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [8*NB-1:0] v;
        for (int k = 0; k < NB; k++) v[8*k +: 8] = exp_bytes[k];
        check({tag, ".busy"}, busy, exp_busy);
        check({tag, ".get_tx_data"}, get_tx_data, exp_get);
        check({tag, ".packet_done"}, packet_done, exp_done);
        check({tag, ".packet_error"}, packet_error, exp_err);
        check({tag, ".packet_len"}, packet_len, exp_len);
        check({tag, ".packet_bits"}, packet_bits, exp_len * 8);
        check({tag, ".packet_tx"}, packet_tx, v);
    endtask

    always @(negedge clk) begin
        if (cmp_en) check_all("cycle");
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] v;
        v = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) v = v[0] ? ((v >> 1) ^ 16'hA001) : (v >> 1);
        return v;
    endfunction

    task automatic model_reset();
        exp_busy = 1'b0; exp_get = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_len = 0;
        for (int k = 0; k < NB; k++) exp_bytes[k] = 8'h00;
    endtask

    // Packet = SYNC, PID, payload, ~crc lo, ~crc hi; bytes appear one per edge,
    // payload bytes only on edges where the FIFO shows valid.
    task automatic send(input logic [3:0] p, input int n, input bit toggle,
                        input int abort_at, input int rst_at);
        logic [7:0]  s [$];
        logic [15:0] c;
        bit          is_data, in_pay, do_abort;
        int          nd, cursor, pc;
        is_data = (p[1:0] == 2'b11);
        nd = is_data ? n : 0;
        s.push_back(8'h01);
        s.push_back({~p, p});
        if (is_data) begin
            c = 16'hFFFF;
            for (int i = 0; i < n; i++) begin
                s.push_back(pay[i]);
                c = crc_upd(c, pay[i]);
            end
            s.push_back(~c[7:0]);
            s.push_back(~c[15:8]);
        end
        start = 1'b1; pid = p; data_count = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < NB; k++) exp_bytes[k] = 8'h00;
        exp_busy = 1'b1; exp_len = 0;
        cursor = 0; pc = 0;
        while (cursor < s.size()) begin
            in_pay  = is_data && cursor >= 2 && cursor < 2 + nd;
            exp_get = in_pay;
            tx_data_valid = in_pay ? (toggle ? (pc % 2 == 0) : 1'b1) : 1'b1;
            tx_data = in_pay ? pay[cursor-2] : 8'hEE;
            // a start while busy must be ignored, even with an illegal pid
            start = toggle && in_pay;
            pid   = 4'b1001;
            if (in_pay) pc++;
            do_abort = in_pay && abort_at >= 0 && cursor == 2 + abort_at;
            abort = do_abort;
            if (do_abort) tx_data_valid = 1'b1;
            if (in_pay && rst_at >= 0 && cursor == 2 + rst_at) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_all("async_rst");
                @(posedge clk); #1;
                rst = 1'b0; start = 1'b0; tx_data_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            if (do_abort) begin
                exp_busy = 1'b0; exp_get = 1'b0; tx_data_valid = 1'b0; start = 1'b0;
                return;
            end
            if (!in_pay || tx_data_valid) begin
                exp_bytes[cursor] = s[cursor];
                cursor++;
                exp_len = cursor;
            end
        end
        start = 1'b0; exp_get = 1'b0; exp_done = 1'b1; tx_data_valid = 1'b0;
        @(posedge clk); #1;
        exp_done = 1'b0; exp_busy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reject(input logic [3:0] p, input int n);
        start = 1'b1; pid = p; data_count = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0; exp_err = 1'b1;
        @(posedge clk); #1;
        exp_err = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 cmp_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ACK handshake
        send(4'b0010, 0, 1'b0, -1, -1);
        check("ack.byte0", packet_tx[7:0], 8'h01);
        check("ack.byte1", packet_tx[15:8], 8'hD2);
        check("ack.len", packet_len, 2);

        // DATA0 "123456789"
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        send(4'b0011, 9, 1'b0, -1, -1);
        check("data0.crc_lo", packet_tx[95:88], 8'hC8);
        check("data0.crc_hi", packet_tx[103:96], 8'hB4);
        check("data0.bits", packet_bits, 104);
        check("data0.byte10", packet_tx[87:80], 8'h39);

        // DATA1 zero length
        send(4'b1011, 0, 1'b0, -1, -1);
        check("data1.pid", packet_tx[15:8], 8'h4B);
        check("data1.crc", packet_tx[31:16], 16'h0000);
        check("data1.len", packet_len, 4);

        // stalled FIFO
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom_range(0, 255));
        send(4'b0011, 4, 1'b1, -1, -1);

        // rejections and idle abort
        reject(4'b0011, MAXB + 1);
        reject(4'b1001, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;

        // full-size packet
        for (int i = 0; i < MAXB; i++) pay[i] = 8'(i * 7 + 3);
        send(4'b0011, MAXB, 1'b0, -1, -1);
        check("max.len", packet_len, NB);

        // abort after three payload bytes
        for (int i = 0; i < 8; i++) pay[i] = 8'hA0 + 8'(i);
        send(4'b1011, 8, 1'b0, 3, -1);
        check("abort.len", packet_len, 5);
        check("abort.byte4", packet_tx[39:32], 8'hA2);
        @(posedge clk); #1;

        // asynchronous reset mid-DATA, then a normal packet
        send(4'b0011, 6, 1'b0, -1, 2);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) pay[i] = 8'h5A + 8'(i);
        send(4'b0011, 2, 1'b0, -1, -1);
        check("after_rst.len", packet_len, 6);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
